// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MEM  = 2'b01;
  localparam logic [1:0] WD_LINK = 2'b10;

  // funct only matters for R-type; every other opcode ignores it.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: return (funct == FUNCT_ADDU) || (funct == FUNCT_SUBU);
      OP_J, OP_JAL, OP_BEQ, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Instruction-field inputs, memory handshake and datapath controls of mips_mc_ctrl.
interface mips_mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_isel;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] npc_sel;
  logic       reg_we;
  logic [1:0] dst_sel;
  logic [1:0] wd_sel;
  logic       alu_b_sel;
  logic [2:0] alu_ctr;
  logic [1:0] ext_op;
  logic       busy;
  logic       err;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_we, mem_isel, ir_we, pc_we, npc_sel, reg_we,
           dst_sel, wd_sel, alu_b_sel, alu_ctr, ext_op, busy, err
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_we, mem_isel, ir_we, pc_we, npc_sel, reg_we,
           dst_sel, wd_sel, alu_b_sel, alu_ctr, ext_op, busy, err
  );
endinterface

// File: rtl/mips_mc_watchdog.sv
// Counts consecutive memory wait cycles; flags the cycle in which the count reaches TIMEOUT.
module mips_mc_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  output logic timeout_o
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  assign cnt_d = wait_i ? cnt_q + TO_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Fires while the TIMEOUT-th wait cycle is in progress, so a late ready still wins.
  assign timeout_o = wait_i && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM sharing one memory port via req/ready.
// Define MIPS_MC_PERF_EN to add the perf_instr/perf_stall counters.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  mips_mc_ctrl_if.master    bus
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_instr,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  if ((PERF_W < 1) || ((1 << TO_W) <= TIMEOUT)) begin : g_bad_params
    $error("mips_mc_ctrl: need PERF_W >= 1 and 2**TO_W > TIMEOUT");
  end

  state_e state_q, state_d;
  logic   mem_wait;
  logic   timeout;

  assign mem_wait = ((state_q == FETCH) || (state_q == MEM)) && !bus.mem_ready;

  mips_mc_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .wait_i    (mem_wait),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Everything is forced low while rst is high so a pending write is dropped at once.
  always_comb begin
    state_d       = state_q;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_isel  = 1'b0;
    bus.ir_we     = 1'b0;
    bus.pc_we     = 1'b0;
    bus.npc_sel   = NPC_PC4;
    bus.reg_we    = 1'b0;
    bus.dst_sel   = DST_RT;
    bus.wd_sel    = WD_ALU;
    bus.alu_b_sel = 1'b0;
    bus.alu_ctr   = ALU_ADD;
    bus.ext_op    = EXT_ZERO;
    bus.busy      = 1'b0;
    bus.err       = 1'b0;
    if (!rst) begin
      bus.busy = (state_q != ERR);
      case (state_q)
        FETCH: begin
          bus.mem_req  = 1'b1;
          bus.mem_isel = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            bus.pc_we = 1'b1;
            state_d   = DECODE;
          end else if (timeout) begin
            state_d = ERR;
          end
        end
        DECODE: begin
          if (!is_legal(bus.op, bus.funct)) begin
            state_d = ERR;
          end else if ((bus.op == OP_J) || (bus.op == OP_JAL)) begin
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_JUMP;
            state_d     = FETCH;
            if (bus.op == OP_JAL) begin
              bus.reg_we  = 1'b1;
              bus.dst_sel = DST_R31;
              bus.wd_sel  = WD_LINK;
            end
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          state_d = WB;
          case (bus.op)
            OP_RTYPE: bus.alu_ctr = (bus.funct == FUNCT_SUBU) ? ALU_SUB : ALU_ADD;
            OP_ORI: begin
              bus.alu_b_sel = 1'b1;
              bus.alu_ctr   = ALU_OR;
            end
            OP_LUI: begin
              bus.ext_op    = EXT_UPPER;
              bus.alu_b_sel = 1'b1;
              bus.alu_ctr   = ALU_LUI;
            end
            OP_LW, OP_SW: begin
              bus.ext_op    = EXT_SIGN;
              bus.alu_b_sel = 1'b1;
              state_d       = MEM;
            end
            OP_BEQ: begin
              bus.alu_ctr = ALU_SUB;
              state_d     = FETCH;
              if (bus.zero) begin
                bus.pc_we   = 1'b1;
                bus.npc_sel = NPC_BRANCH;
              end
            end
            default: state_d = ERR;
          endcase
        end
        MEM: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = (bus.op == OP_SW);
          if (bus.mem_ready)  state_d = (bus.op == OP_LW) ? WB : FETCH;
          else if (timeout)   state_d = ERR;
        end
        WB: begin
          bus.reg_we = 1'b1;
          state_d    = FETCH;
          if (bus.op == OP_LW)         bus.wd_sel  = WD_MEM;
          else if (bus.op == OP_RTYPE) bus.dst_sel = DST_RD;
        end
        ERR:     bus.err = 1'b1;
        default: state_d = ERR;
      endcase
    end
  end

`ifdef MIPS_MC_PERF_EN
  logic [PERF_W-1:0] perf_instr_q;
  logic [PERF_W-1:0] perf_stall_q;

  // An instruction retires whenever the FSM heads back to FETCH from a working state.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((state_d == FETCH) && (state_q inside {DECODE, EXEC, MEM, WB}))
        perf_instr_q <= perf_instr_q + PERF_W'(1);
      if (mem_wait)
        perf_stall_q <= perf_stall_q + PERF_W'(1);
    end
  end

  assign perf_instr = perf_instr_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: directed per-cycle vectors, monitor compares at negedge.
module tb_mips_mc_ctrl;
  import mips_mc_pkg::*;

  typedef logic [19:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t  expQ[$];
  string tagQ[$];
  vec_t  actual;

  always #5 clk = ~clk;

  mips_mc_ctrl_if bus ();

`ifdef MIPS_MC_PERF_EN
  logic [31:0] perfInstr;
  logic [31:0] perfStall;
`endif

  mips_mc_ctrl #(.TIMEOUT(16), .TO_W(5), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MIPS_MC_PERF_EN
    ,
    .perf_instr (perfInstr),
    .perf_stall (perfStall)
`endif
  );

  assign actual = {bus.mem_req, bus.mem_we, bus.mem_isel, bus.ir_we, bus.pc_we, bus.npc_sel,
                   bus.reg_we, bus.dst_sel, bus.wd_sel, bus.alu_b_sel, bus.alu_ctr,
                   bus.ext_op, bus.busy, bus.err};

  function automatic vec_t mk(input logic memReq, memWe, memIsel, irWe, pcWe,
                              input logic [1:0] npcSel, input logic regWe,
                              input logic [1:0] dstSel, wdSel, input logic aluBSel,
                              input logic [2:0] aluCtr, input logic [1:0] extOp,
                              input logic busy, err);
    return {memReq, memWe, memIsel, irWe, pcWe, npcSel, regWe, dstSel, wdSel,
            aluBSel, aluCtr, extOp, busy, err};
  endfunction

  // Hand-derived output vector for each controller situation.
  localparam vec_t RST_V     = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'b000,2'b00,0,0);
  localparam vec_t FWAIT_V   = mk(1,0,1,0,0,2'b00,0,2'b00,2'b00,0,3'b000,2'b00,1,0);
  localparam vec_t FGO_V     = mk(1,0,1,1,1,2'b00,0,2'b00,2'b00,0,3'b000,2'b00,1,0);
  localparam vec_t DEC_V     = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'b000,2'b00,1,0);
  localparam vec_t DEC_J_V   = mk(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,3'b000,2'b00,1,0);
  localparam vec_t DEC_JAL_V = mk(0,0,0,0,1,2'b10,1,2'b10,2'b10,0,3'b000,2'b00,1,0);
  localparam vec_t EX_ADD_V  = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'b000,2'b00,1,0);
  localparam vec_t EX_SUB_V  = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'b001,2'b00,1,0);
  localparam vec_t EX_ORI_V  = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,3'b010,2'b00,1,0);
  localparam vec_t EX_LUI_V  = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,3'b011,2'b10,1,0);
  localparam vec_t EX_MEM_V  = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,3'b000,2'b01,1,0);
  localparam vec_t EX_BT_V   = mk(0,0,0,0,1,2'b01,0,2'b00,2'b00,0,3'b001,2'b00,1,0);
  localparam vec_t EX_BN_V   = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'b001,2'b00,1,0);
  localparam vec_t MEM_LW_V  = mk(1,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'b000,2'b00,1,0);
  localparam vec_t MEM_SW_V  = mk(1,1,0,0,0,2'b00,0,2'b00,2'b00,0,3'b000,2'b00,1,0);
  localparam vec_t WB_LW_V   = mk(0,0,0,0,0,2'b00,1,2'b00,2'b01,0,3'b000,2'b00,1,0);
  localparam vec_t WB_R_V    = mk(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,3'b000,2'b00,1,0);
  localparam vec_t WB_I_V    = mk(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,3'b000,2'b00,1,0);
  localparam vec_t ERR_V     = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'b000,2'b00,0,1);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // Drives one cycle of inputs, queues what the DUT must show, then advances to posedge+1.
  task automatic applyStimulus(input string tag, input logic r, input logic [5:0] op,
                               input logic [5:0] funct, input logic zero, input logic ready,
                               input vec_t expV);
    rst           = r;
    bus.op        = op;
    bus.funct     = funct;
    bus.zero      = zero;
    bus.mem_ready = ready;
    expQ.push_back(expV);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] funct,
                       input int waits);
    for (int i = 0; i < waits; i++) applyStimulus({tag, "_fwait"}, 0, op, funct, 0, 0, FWAIT_V);
    applyStimulus({tag, "_fetch"}, 0, op, funct, 0, 1, FGO_V);
  endtask

  initial begin : monitor
    vec_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(t, {12'h0, actual}, {12'h0, e});
      end
    end
  end

  initial begin : timeLimit
    #100000;
    $display("[TB] FAIL time_limit got running expected finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin : stimulus
    rst = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("rst0", 1, 0, 0, 0, 1, RST_V);
    applyStimulus("rst1", 1, 0, 0, 0, 1, RST_V);

    fetch("addu", OP_RTYPE, FUNCT_ADDU, 0);
    applyStimulus("addu_dec",  0, OP_RTYPE, FUNCT_ADDU, 0, 1, DEC_V);
    applyStimulus("addu_exec", 0, OP_RTYPE, FUNCT_ADDU, 0, 1, EX_ADD_V);
    applyStimulus("addu_wb",   0, OP_RTYPE, FUNCT_ADDU, 0, 1, WB_R_V);

    fetch("subu", OP_RTYPE, FUNCT_SUBU, 2);
    applyStimulus("subu_dec",  0, OP_RTYPE, FUNCT_SUBU, 0, 1, DEC_V);
    applyStimulus("subu_exec", 0, OP_RTYPE, FUNCT_SUBU, 0, 1, EX_SUB_V);
    applyStimulus("subu_wb",   0, OP_RTYPE, FUNCT_SUBU, 0, 1, WB_R_V);

    fetch("ori", OP_ORI, 6'h3F, 0);
    applyStimulus("ori_dec",  0, OP_ORI, 6'h3F, 0, 1, DEC_V);
    applyStimulus("ori_exec", 0, OP_ORI, 6'h3F, 0, 1, EX_ORI_V);
    applyStimulus("ori_wb",   0, OP_ORI, 6'h3F, 0, 1, WB_I_V);

    fetch("lui", OP_LUI, 0, 0);
    applyStimulus("lui_dec",  0, OP_LUI, 0, 0, 1, DEC_V);
    applyStimulus("lui_exec", 0, OP_LUI, 0, 0, 1, EX_LUI_V);
    applyStimulus("lui_wb",   0, OP_LUI, 0, 0, 1, WB_I_V);

    fetch("lw", OP_LW, 0, 0);
    applyStimulus("lw_dec",  0, OP_LW, 0, 0, 1, DEC_V);
    applyStimulus("lw_exec", 0, OP_LW, 0, 0, 1, EX_MEM_V);
    for (int i = 0; i < 3; i++) applyStimulus("lw_mwait", 0, OP_LW, 0, 0, 0, MEM_LW_V);
    applyStimulus("lw_mem", 0, OP_LW, 0, 0, 1, MEM_LW_V);
    applyStimulus("lw_wb",  0, OP_LW, 0, 0, 1, WB_LW_V);

    fetch("sw", OP_SW, 0, 0);
    applyStimulus("sw_dec",   0, OP_SW, 0, 0, 1, DEC_V);
    applyStimulus("sw_exec",  0, OP_SW, 0, 0, 1, EX_MEM_V);
    applyStimulus("sw_mwait", 0, OP_SW, 0, 0, 0, MEM_SW_V);
    applyStimulus("sw_mem",   0, OP_SW, 0, 0, 1, MEM_SW_V);

    fetch("beqT", OP_BEQ, 0, 0);
    applyStimulus("beqT_dec",  0, OP_BEQ, 0, 1, 1, DEC_V);
    applyStimulus("beqT_exec", 0, OP_BEQ, 0, 1, 1, EX_BT_V);
    fetch("beqN", OP_BEQ, 0, 0);
    applyStimulus("beqN_dec",  0, OP_BEQ, 0, 0, 1, DEC_V);
    applyStimulus("beqN_exec", 0, OP_BEQ, 0, 0, 1, EX_BN_V);

    fetch("j", OP_J, 0, 0);
    applyStimulus("j_dec", 0, OP_J, 0, 0, 1, DEC_J_V);
    fetch("jal", OP_JAL, 0, 0);
    applyStimulus("jal_dec", 0, OP_JAL, 0, 0, 1, DEC_JAL_V);

    // Ready arriving on the 16th wait cycle must beat the watchdog.
    fetch("wdok", OP_J, 0, 15);
    applyStimulus("wdok_dec", 0, OP_J, 0, 0, 1, DEC_J_V);

    fetch("wdf", OP_J, 0, 0);
    applyStimulus("wdf_dec", 0, OP_J, 0, 0, 1, DEC_J_V);
    for (int i = 0; i < 16; i++) applyStimulus("wdf_fwait", 0, OP_J, 0, 0, 0, FWAIT_V);
    applyStimulus("wdf_err0", 0, OP_J, 0, 0, 1, ERR_V);
    applyStimulus("wdf_err1", 0, OP_J, 0, 0, 0, ERR_V);
    applyStimulus("wdf_rst",  1, OP_J, 0, 0, 0, RST_V);

    fetch("wdm", OP_LW, 0, 0);
    applyStimulus("wdm_dec",  0, OP_LW, 0, 0, 1, DEC_V);
    applyStimulus("wdm_exec", 0, OP_LW, 0, 0, 1, EX_MEM_V);
    for (int i = 0; i < 16; i++) applyStimulus("wdm_mwait", 0, OP_LW, 0, 0, 0, MEM_LW_V);
    applyStimulus("wdm_err", 0, OP_LW, 0, 0, 1, ERR_V);
    applyStimulus("wdm_rst", 1, OP_LW, 0, 0, 1, RST_V);

    fetch("illop", 6'h3F, 0, 0);
    applyStimulus("illop_dec",  0, 6'h3F, 0, 0, 1, DEC_V);
    applyStimulus("illop_err0", 0, 6'h3F, 0, 0, 1, ERR_V);
    applyStimulus("illop_err1", 0, OP_RTYPE, FUNCT_ADDU, 0, 1, ERR_V);
    applyStimulus("illop_rst",  1, 6'h3F, 0, 0, 1, RST_V);

    fetch("illfn", OP_RTYPE, 6'h20, 0);
    applyStimulus("illfn_dec", 0, OP_RTYPE, 6'h20, 0, 1, DEC_V);
    applyStimulus("illfn_err", 0, OP_RTYPE, 6'h20, 0, 1, ERR_V);
    applyStimulus("illfn_rst", 1, OP_RTYPE, 6'h20, 0, 1, RST_V);

    // Reset while a store waits: the request must vanish in the reset cycle itself.
    fetch("swr", OP_SW, 0, 0);
    applyStimulus("swr_dec",   0, OP_SW, 0, 0, 1, DEC_V);
    applyStimulus("swr_exec",  0, OP_SW, 0, 0, 1, EX_MEM_V);
    applyStimulus("swr_mwait", 0, OP_SW, 0, 0, 0, MEM_SW_V);
    applyStimulus("swr_rst",   1, OP_SW, 0, 0, 0, RST_V);
    fetch("after", OP_RTYPE, FUNCT_ADDU, 0);

`ifdef MIPS_MC_PERF_EN
    applyStimulus("perf_rst", 1, 0, 0, 0, 1, RST_V);
    fetch("paddu", OP_RTYPE, FUNCT_ADDU, 1);
    applyStimulus("paddu_dec",  0, OP_RTYPE, FUNCT_ADDU, 0, 1, DEC_V);
    applyStimulus("paddu_exec", 0, OP_RTYPE, FUNCT_ADDU, 0, 1, EX_ADD_V);
    applyStimulus("paddu_wb",   0, OP_RTYPE, FUNCT_ADDU, 0, 1, WB_R_V);
    fetch("psw", OP_SW, 0, 0);
    applyStimulus("psw_dec",  0, OP_SW, 0, 0, 1, DEC_V);
    applyStimulus("psw_exec", 0, OP_SW, 0, 0, 1, EX_MEM_V);
    for (int i = 0; i < 2; i++) applyStimulus("psw_mwait", 0, OP_SW, 0, 0, 0, MEM_SW_V);
    applyStimulus("psw_mem", 0, OP_SW, 0, 0, 1, MEM_SW_V);
    fetch("pj", OP_J, 0, 0);
    applyStimulus("pj_dec", 0, OP_J, 0, 0, 1, DEC_J_V);
    checkOutput("perf_instr", perfInstr, 32'd3);
    checkOutput("perf_stall", perfStall, 32'd3);
`endif

    repeat (2) @(negedge clk);
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
